// File: rtl/sdram_request_arbiter_pkg.sv
// Shared encodings for the SDRAM request arbiter: controller opcodes,
// arbiter FSM states and the word-address field layout.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_REFRESH = 2'b10
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } arb_state_e;

  // Word address layout: bank[23:22], row[21:9], col[8:0]
  localparam int BANK_MSB = 23;
  localparam int BANK_LSB = 22;
  localparam int ROW_MSB  = 21;
  localparam int ROW_LSB  = 9;
  localparam int COL_MSB  = 8;
  localparam int COL_LSB  = 0;

endpackage

// File: rtl/sdram_request_arbiter_if.sv
// Client request/response and controller command bundle. The arbiter sits
// on the slave modport; the clients/controller side uses master.
interface sdram_request_arbiter_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_we;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        ctrl_ready;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [1:0]                  cmd_op;
  logic [ADDR_W-1:0]           cmd_addr;
  logic [DATA_W-1:0]           cmd_wdata;
  logic                        ctrl_done;
  logic [DATA_W-1:0]           ctrl_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  ctrl_ready, cmd_ready, ctrl_done, ctrl_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output ctrl_ready, cmd_ready, ctrl_done, ctrl_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata
  );
endinterface

// File: rtl/sdram_request_arbiter_refresh_timer.sv
// Refresh schedule: interval counter producing a tick, plus a saturating
// refresh-debt counter with a sticky overflow flag.
module sdram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 1250,
  parameter int URGENT_DEBT      = 4,
  parameter int MAX_DEBT         = 8,
  parameter int DEBT_W           = $clog2(MAX_DEBT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_ready_i,
  input  logic              refresh_done_i,
  output logic [DEBT_W-1:0] debt_o,
  output logic              urgent_o,
  output logic              overflow_o
);
  localparam int CNT_W = $clog2(REFRESH_INTERVAL);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              ovf_q, ovf_d;
  logic              tick;

  assign tick = ctrl_ready_i && (cnt_q == CNT_W'(REFRESH_INTERVAL - 1));

  // Interval counter: frozen at 0 until the controller is initialised
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!ctrl_ready_i || tick) cnt_d = '0;
  end

  // Debt: +1 per tick (saturating), -1 per finished refresh; both cancel
  always_comb begin
    debt_d = debt_q;
    ovf_d  = ovf_q | (tick && (debt_q == DEBT_W'(MAX_DEBT)));
    if (tick && !refresh_done_i) begin
      if (debt_q != DEBT_W'(MAX_DEBT)) debt_d = debt_q + 1'b1;
    end else if (refresh_done_i && !tick) begin
      if (debt_q != '0) debt_d = debt_q - 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign debt_o     = debt_q;
  assign urgent_o   = (debt_q >= DEBT_W'(URGENT_DEBT));
  assign overflow_o = ovf_q;

endmodule

// File: rtl/sdram_request_arbiter.sv
// Round-robin arbiter sharing one SDRAM command controller among
// NUM_PORTS clients, interleaving auto-refresh from the refresh debt.
// One transaction outstanding at a time.
module sdram_request_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS        = 3,
  parameter int ADDR_W           = 24,
  parameter int DATA_W           = 16,
  parameter int REFRESH_INTERVAL = 1250,
  parameter int URGENT_DEBT      = 4,
  parameter int MAX_DEBT         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sdram_request_arbiter_if.slave bus,
  output logic                   refresh_overflow
);
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEBT_W = $clog2(MAX_DEBT + 1);

  arb_state_e            state_q, state_d;
  cmd_op_e               op_q, op_d;
  logic [PW-1:0]         rr_ptr_q, rr_d;
  logic [PW-1:0]         gnt_q, gnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [NUM_PORTS-1:0]  req_ready_c;
  logic                  refresh_done;
  logic [DEBT_W-1:0]     debt;
  logic                  urgent;
  logic                  found;
  logic [PW-1:0]         pick;
  int unsigned           idx;

  sdram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .URGENT_DEBT      (URGENT_DEBT),
    .MAX_DEBT         (MAX_DEBT),
    .DEBT_W           (DEBT_W)
  ) u_rt (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_ready_i   (bus.ctrl_ready),
    .refresh_done_i (refresh_done),
    .debt_o         (debt),
    .urgent_o       (urgent),
    .overflow_o     (refresh_overflow)
  );

  // Round-robin search: first valid port at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // FSM next state, latched command and per-cycle strobes
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rr_d         = rr_ptr_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    req_ready_c  = '0;
    refresh_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ctrl_ready) begin
          if (urgent) begin
            op_d    = OP_REFRESH;
            addr_d  = '0;
            wdata_d = '0;
            state_d = S_ISSUE;
          end else if (found) begin
            gnt_d   = pick;
            op_d    = bus.req_we[pick] ? OP_WRITE : OP_READ;
            addr_d  = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
            wdata_d = bus.req_wdata[int'(pick)*DATA_W +: DATA_W];
            state_d = S_ISSUE;
          end else if (debt != '0) begin
            // Bus is idle: pay refresh debt opportunistically
            op_d    = OP_REFRESH;
            addr_d  = '0;
            wdata_d = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ready) begin
          state_d = S_WAIT;
          if (op_q != OP_REFRESH) begin
            req_ready_c[gnt_q] = 1'b1;
            rr_d = (int'(gnt_q) == NUM_PORTS - 1) ? '0 : gnt_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (bus.ctrl_done) begin
          state_d = S_IDLE;
          if (op_q == OP_REFRESH) begin
            refresh_done = 1'b1;
          end else begin
            rsp_valid_d[gnt_q] = 1'b1;
            if (op_q == OP_READ) rsp_rdata_d = bus.ctrl_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rr_ptr_q    <= rr_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_valid = (state_q == S_ISSUE);
  assign bus.cmd_op    = bus.cmd_valid ? op_q : 2'b00;
  assign bus.cmd_addr  = bus.cmd_valid ? addr_q : '0;
  assign bus.cmd_wdata = bus.cmd_valid ? wdata_q : '0;
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Scoreboard bench for sdram_request_arbiter: a controller/client engine
// drives the bus, directed expectations are queued, and negedge monitors
// pop and compare every command handshake and every response pulse.
module tb_sdram_request_arbiter;
  import sdram_arb_pkg::*;

  localparam int NP = 3;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int RI = 1250;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NP-1:0] rdy;
  } exp_cmd_t;

  typedef struct packed {
    logic [NP-1:0] port;
    logic [DW-1:0] rdata;
  } exp_rsp_t;

  logic clk;
  logic rst_n;
  logic refresh_overflow;

  sdram_request_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_request_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
    .REFRESH_INTERVAL(RI), .URGENT_DEBT(4), .MAX_DEBT(8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .refresh_overflow (refresh_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  req_t     cq[NP][$];
  exp_cmd_t exp_cmd[$];
  exp_rsp_t exp_rsp[$];

  bit            cmd_ready_en = 1'b1;
  int            ctrl_lat     = 2;
  bit            auto1        = 1'b0;
  logic [AW-1:0] auto_addr    = 24'h001000;
  int            refresh_seen = 0;
  int            cmd_seen     = 0;
  int            max_debt     = 0;
  bit            hs_cmd       = 1'b0;
  logic [1:0]    hs_op        = 2'b00;
  logic [AW-1:0] hs_addr      = '0;
  logic [NP-1:0] hs_req       = '0;
  bit            done_prev    = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r = '{we: we, addr: a, wdata: d};
    cq[p].push_back(r);
  endtask

  task automatic expect_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [NP-1:0] rdy);
    exp_cmd_t e;
    e = '{op: op, addr: a, wdata: d, rdy: rdy};
    exp_cmd.push_back(e);
  endtask

  task automatic expect_rsp(input logic [NP-1:0] port, input logic [DW-1:0] rd);
    exp_rsp_t e;
    e = '{port: port, rdata: rd};
    exp_rsp.push_back(e);
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_cmd.size() != 0 || exp_rsp.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    chk({nm, " drained"}, 64'(exp_cmd.size() + exp_rsp.size()), 64'd0);
  endtask

  // Controller + client model: controller completes each command ctrl_lat
  // cycles after acceptance with data addr^A5A5 (reads) or junk (writes);
  // clients hold each request until accepted, then present the next.
  initial begin
    int   pend;
    logic [DW-1:0] pend_rdata;
    logic [NP-1:0] v, we;
    logic [NP*AW-1:0] ad;
    logic [NP*DW-1:0] wd;
    req_t r;
    pend = 0;
    pend_rdata = '0;
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.cmd_ready = 1'b0;
    bus.ctrl_done = 1'b0;
    bus.ctrl_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ctrl_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.ctrl_done  = 1'b1;
          bus.ctrl_rdata = pend_rdata;
        end
      end
      if (hs_cmd) begin
        hs_cmd = 1'b0;
        pend = ctrl_lat;
        pend_rdata = (hs_op == OP_READ) ? (hs_addr[DW-1:0] ^ 16'hA5A5) : 16'hDEAD;
      end
      for (int p = 0; p < NP; p++)
        if (hs_req[p] && cq[p].size() > 0) void'(cq[p].pop_front());
      hs_req = '0;
      if (auto1 && cq[1].size() == 0) begin
        issue(1, 1'b0, auto_addr, 16'h0000);
        expect_cmd(OP_READ, auto_addr, 16'h0000, 3'b010);
        expect_rsp(3'b010, auto_addr[DW-1:0] ^ 16'hA5A5);
        auto_addr = auto_addr + 24'd1;
      end
      v = '0; we = '0; ad = '0; wd = '0;
      for (int p = 0; p < NP; p++) begin
        if (cq[p].size() > 0) begin
          r = cq[p][0];
          v[p] = 1'b1;
          we[p] = r.we;
          ad[p*AW +: AW] = r.addr;
          wd[p*DW +: DW] = r.wdata;
        end
      end
      bus.req_valid = v;
      bus.req_we = we;
      bus.req_addr = ad;
      bus.req_wdata = wd;
      bus.cmd_ready = cmd_ready_en;
    end
  end

  // Command monitor: every accepted command is popped against the queue
  initial begin
    exp_cmd_t e;
    forever begin
      @(negedge clk);
      if (!$onehot0(bus.req_ready) || !$onehot0(bus.rsp_valid)) begin
        tests++;
        fails++;
        $display("FAIL onehot: req_ready=%b rsp_valid=%b", bus.req_ready, bus.rsp_valid);
      end
      if (bus.cmd_valid) cmd_seen++;
      if (int'(dut.u_rt.debt_q) > max_debt) max_debt = int'(dut.u_rt.debt_q);
      if (bus.cmd_valid && bus.cmd_ready) begin
        hs_cmd  = 1'b1;
        hs_op   = bus.cmd_op;
        hs_addr = bus.cmd_addr;
        if (bus.cmd_op == OP_REFRESH) begin
          refresh_seen++;
          chk("refresh cmd addr/wdata/req_ready", {bus.cmd_addr, bus.cmd_wdata, bus.req_ready}, 64'd0);
        end else if (exp_cmd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected cmd: op=%0h addr=%0h", bus.cmd_op, bus.cmd_addr);
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd op/addr/wdata/req_ready",
              {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata, bus.req_ready},
              {e.op, e.addr, e.wdata, e.rdy});
        end
      end
      hs_req = hs_req | bus.req_ready;
    end
  end

  // Response monitor: each rsp pulse must follow ctrl_done by one cycle
  initial begin
    exp_rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin
        chk("rsp one cycle after ctrl_done", 64'(done_prev), 64'd1);
        if (exp_rsp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected rsp: port=%b rdata=%0h", bus.rsp_valid, bus.rsp_rdata);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp port/rdata", {bus.rsp_valid, bus.rsp_rdata}, {e.port, e.rdata});
        end
      end
      done_prev = bus.ctrl_done;
    end
  end

  initial begin
    int n;
    int rs0;
    int cs0;
    rst_n = 1'b1;
    bus.ctrl_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset outputs",
        {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.cmd_wdata, bus.req_ready,
         bus.rsp_valid, bus.rsp_rdata, refresh_overflow}, 64'd0);
    step(3);
    rst_n = 1'b1;

    // 1: controller not ready, all ports requesting
    issue(0, 1'b0, 24'h000010, 16'h0000);
    issue(0, 1'b0, 24'h000040, 16'h0000);
    issue(1, 1'b0, 24'h000020, 16'h0000);
    issue(2, 1'b0, 24'h000030, 16'h0000);
    step(100);
    chk("no cmd while !ctrl_ready", 64'(cmd_seen), 64'd0);
    chk("debt held 0", 64'(dut.u_rt.debt_q), 64'd0);
    chk("timer held 0", 64'(dut.u_rt.cnt_q), 64'd0);

    // 2: round robin 0,1,2,0 then a write on port 1
    expect_cmd(OP_READ, 24'h000010, 16'h0000, 3'b001);
    expect_cmd(OP_READ, 24'h000020, 16'h0000, 3'b010);
    expect_cmd(OP_READ, 24'h000030, 16'h0000, 3'b100);
    expect_cmd(OP_READ, 24'h000040, 16'h0000, 3'b001);
    expect_rsp(3'b001, 16'hA5B5);
    expect_rsp(3'b010, 16'hA585);
    expect_rsp(3'b100, 16'hA595);
    expect_rsp(3'b001, 16'hA5E5);
    bus.ctrl_ready = 1'b1;
    wait_empty("rr reads", 200);
    issue(1, 1'b1, 24'h123456, 16'hBEEF);
    expect_cmd(OP_WRITE, 24'h123456, 16'hBEEF, 3'b010);
    expect_rsp(3'b010, 16'h0000);
    wait_empty("write", 100);
    chk("rr_ptr after port1 grant", 64'(dut.rr_ptr_q), 64'd2);

    // 3: idle bus -> one opportunistic refresh after the first tick
    rs0 = refresh_seen;
    n = 0;
    while (dut.u_rt.debt_q == 0 && n < 1500) begin step(1); n++; end
    chk("debt after first tick", 64'(dut.u_rt.debt_q), 64'd1);
    n = 0;
    while (refresh_seen == rs0 && n < 50) begin step(1); n++; end
    step(10);
    chk("opportunistic refresh count", 64'(refresh_seen - rs0), 64'd1);
    chk("debt repaid", 64'(dut.u_rt.debt_q), 64'd0);

    // 4: saturated port 1 -> urgent refresh caps debt at 4
    rs0 = refresh_seen;
    max_debt = 0;
    auto1 = 1'b1;
    step(5 * RI);
    auto1 = 1'b0;
    wait_empty("saturation", 100);
    chk("max debt under load", 64'(max_debt), 64'd4);
    chk("urgent refresh happened", 64'(refresh_seen > rs0), 64'd1);
    chk("no overflow under load", 64'(refresh_overflow), 64'd0);

    // 5: controller stalled -> debt saturates, then overflow sticks
    n = 0;
    while (dut.u_rt.debt_q != 0 && n < 300) begin step(1); n++; end
    chk("debt drained before stall", 64'(dut.u_rt.debt_q), 64'd0);
    cmd_ready_en = 1'b0;
    n = 0;
    while (dut.u_rt.debt_q != 8 && n < 8 * RI + 20) begin step(1); n++; end
    chk("debt saturates at 8", 64'(dut.u_rt.debt_q), 64'd8);
    chk("no overflow at debt 8", 64'(refresh_overflow), 64'd0);
    n = 0;
    while (!refresh_overflow && n < RI + 20) begin step(1); n++; end
    chk("overflow on tick at max", 64'(refresh_overflow), 64'd1);
    chk("debt stays 8", 64'(dut.u_rt.debt_q), 64'd8);
    cmd_ready_en = 1'b1;
    n = 0;
    while (dut.u_rt.debt_q != 0 && n < 300) begin step(1); n++; end
    chk("debt drained after stall", 64'(dut.u_rt.debt_q), 64'd0);
    chk("overflow sticky", 64'(refresh_overflow), 64'd1);

    // 6: reset during WAIT of a port-2 write drops the transaction
    ctrl_lat = 30;
    issue(2, 1'b1, 24'h3ABCDE, 16'h1234);
    expect_cmd(OP_WRITE, 24'h3ABCDE, 16'h1234, 3'b100);
    n = 0;
    while (exp_cmd.size() != 0 && n < 50) begin step(1); n++; end
    step(3);
    chk("in WAIT before reset", 64'(dut.state_q), 64'(S_WAIT));
    rst_n = 1'b0;
    #1;
    chk("async reset outputs",
        {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.cmd_wdata, bus.req_ready,
         bus.rsp_valid, bus.rsp_rdata, refresh_overflow}, 64'd0);
    chk("rr_ptr/debt after reset", {32'(dut.rr_ptr_q), 32'(dut.u_rt.debt_q)}, 64'd0);
    step(2);
    rst_n = 1'b1;
    cs0 = cmd_seen;
    step(60);
    chk("no cmd after reset", 64'(cmd_seen - cs0), 64'd0);
    chk("no pending expectations", 64'(exp_cmd.size() + exp_rsp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
